// File: rtl/phone_line.sv
// phone_line: per-subscriber call-state controller reporting busy status and dialled number
module phone_line #(
    parameter logic [3:0] OWN_ID       = 4'd0,
    parameter int         RING_TIMEOUT = 8
) (
    input  logic       clock,
    input  logic       reset,
    input  logic [3:0] id,
    input  logic       send,
    input  logic       recv,
    output logic       status,
    output logic [3:0] number
);
    localparam logic [2:0] IDLE    = 3'd0;
    localparam logic [2:0] CALLING = 3'd1;
    localparam logic [2:0] RINGING = 3'd2;
    localparam logic [2:0] TALKING = 3'd3;
    localparam logic [2:0] BUSY    = 3'd4;

    logic [2:0] state, nxt_state;
    logic [3:0] timer, nxt_num;
    logic       send_q, sev, timeout, self_call;

    assign sev       = send & ~send_q;
    assign timeout   = timer == 4'(RING_TIMEOUT - 1);
    assign self_call = (id == OWN_ID) || (id == 4'hF);

    always_comb begin
        nxt_state = IDLE;
        nxt_num   = 4'hF;
        case (state)
            IDLE: begin
                nxt_state = sev ? (self_call ? BUSY : CALLING) : (recv ? RINGING : IDLE);
                nxt_num   = (sev && !self_call) ? id : 4'hF;
            end
            CALLING: begin
                nxt_state = sev ? IDLE : recv ? TALKING : timeout ? BUSY : CALLING;
                nxt_num   = (!sev && (recv || !timeout)) ? number : 4'hF;
            end
            RINGING: nxt_state = sev ? TALKING : (!recv || timeout) ? IDLE : RINGING;
            TALKING: begin
                nxt_state = sev ? IDLE : recv ? TALKING : BUSY;
                nxt_num   = (!sev && recv) ? number : 4'hF;
            end
            BUSY:    nxt_state = sev ? IDLE : BUSY;
            default: nxt_state = IDLE;
        endcase
    end

    // timer restarts on every transition and only advances while waiting for an answer
    always_ff @(posedge clock) begin
        if (reset) begin
            state  <= IDLE;
            status <= 1'b0;
            number <= 4'hF;
            timer  <= 4'd0;
            send_q <= 1'b0;
        end else begin
            state  <= nxt_state;
            status <= nxt_state != IDLE;
            number <= nxt_num;
            send_q <= send;
            timer  <= (nxt_state != state) ? 4'd0 :
                      (state == CALLING || state == RINGING) ? timer + 4'd1 : timer;
        end
    end
endmodule

// File: tb/tb_phone_line.sv
// tb_phone_line: vector table, timeout sequences and randomized run against a call-behaviour model
module tb_phone_line;
    localparam int RT = 8;

    logic       clock = 1'b0;
    logic       reset = 1'b1;
    logic [3:0] id = 4'd0;
    logic       send = 1'b0;
    logic       recv = 1'b0;
    logic       status;
    logic [3:0] number;

    int n_tests = 0;
    int n_fail  = 0;

    phone_line #(.OWN_ID(4'd0), .RING_TIMEOUT(RT)) dut (
        .clock (clock),
        .reset (reset),
        .id    (id),
        .send  (send),
        .recv  (recv),
        .status(status),
        .number(number)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic       r;
        logic [3:0] i;
        logic       s;
        logic       v;
        logic       st;
        logic [3:0] num;
    } vec_t;

    vec_t tbl[$];

    string      m_mode = "idle";
    int         m_age  = 0;
    logic       m_sq   = 1'b0;
    logic [3:0] m_num  = 4'hF;

    // behavioural view: a mode name, how many edges it has lasted, and the dialled number
    function automatic void model(input logic r, input logic [3:0] i, input logic s, input logic v);
        logic  press;
        string prev;
        bit    expired;
        if (r) begin
            m_mode = "idle"; m_age = 0; m_sq = 1'b0; m_num = 4'hF;
            return;
        end
        press   = s && !m_sq;
        m_sq    = s;
        prev    = m_mode;
        expired = (m_age + 1) >= RT;
        if (m_mode == "idle") begin
            if (press && (i == 4'd0 || i == 4'hF)) begin m_mode = "busy"; m_num = 4'hF; end
            else if (press) begin m_mode = "calling"; m_num = i; end
            else if (v) m_mode = "ringing";
        end else if (m_mode == "calling") begin
            if (press) begin m_mode = "idle"; m_num = 4'hF; end
            else if (v) m_mode = "talking";
            else if (expired) begin m_mode = "busy"; m_num = 4'hF; end
        end else if (m_mode == "ringing") begin
            if (press) m_mode = "talking";
            else if (!v || expired) m_mode = "idle";
        end else if (m_mode == "talking") begin
            if (press || !v) begin m_mode = press ? "idle" : "busy"; m_num = 4'hF; end
        end else if (press) m_mode = "idle";
        m_age = (m_mode == prev) ? m_age + 1 : 0;
    endfunction

    task automatic step(input logic r, input logic [3:0] i, input logic s, input logic v);
        reset = r; id = i; send = s; recv = v;
        @(posedge clock);
        model(r, i, s, v);
        #1;
    endtask

    task automatic check(input string name, input logic st, input logic [3:0] num);
        n_tests++;
        if (status !== st || number !== num) begin
            n_fail++;
            $display("FAIL %s: got status=%0b number=%h, expected status=%0b number=%h",
                     name, status, number, st, num);
        end
    endtask

    function automatic void add(input logic r, input logic [3:0] i, input logic s, input logic v,
                                input logic st, input logic [3:0] num);
        vec_t t;
        t.r = r; t.i = i; t.s = s; t.v = v; t.st = st; t.num = num;
        tbl.push_back(t);
    endfunction

    initial begin
        add(1, 0, 0, 0, 0, 4'hF);
        for (int k = 0; k < 5; k++) add(0, 0, 0, 0, 0, 4'hF);
        add(0, 3, 1, 0, 1, 4'd3);
        add(0, 3, 0, 1, 1, 4'd3);
        add(0, 3, 1, 1, 0, 4'hF);
        add(0, 3, 0, 0, 0, 4'hF);
        add(0, 0, 1, 0, 1, 4'hF);
        for (int k = 0; k < 4; k++) add(0, 0, 1, 0, 1, 4'hF);
        add(0, 0, 0, 1, 1, 4'hF);
        add(0, 0, 1, 0, 0, 4'hF);
        add(0, 0, 0, 0, 0, 4'hF);
        add(0, 0, 0, 1, 1, 4'hF);
        add(0, 0, 1, 1, 1, 4'hF);
        add(0, 0, 0, 0, 1, 4'hF);
        add(0, 0, 1, 0, 0, 4'hF);
        add(0, 0, 0, 0, 0, 4'hF);
        add(0, 7, 1, 0, 1, 4'd7);
        add(0, 7, 0, 0, 1, 4'd7);
        add(0, 7, 1, 0, 0, 4'hF);
        add(0, 7, 0, 0, 0, 4'hF);
        add(0, 5, 1, 1, 1, 4'd5);
        add(0, 5, 0, 1, 1, 4'd5);
        add(1, 5, 0, 1, 0, 4'hF);
        add(0, 5, 0, 0, 0, 4'hF);
        add(0, 4'hF, 1, 0, 1, 4'hF);
        add(0, 4'hF, 0, 0, 1, 4'hF);
        add(0, 4'hF, 1, 0, 0, 4'hF);
        add(0, 4'hF, 0, 0, 0, 4'hF);

        foreach (tbl[k]) begin
            step(tbl[k].r, tbl[k].i, tbl[k].s, tbl[k].v);
            check($sformatf("vec%0d", k), tbl[k].st, tbl[k].num);
        end

        step(0, 9, 1, 0);
        check("call_enter", 1, 4'd9);
        for (int k = 1; k < RT; k++) begin
            step(0, 9, 0, 0);
            check($sformatf("call_wait%0d", k), 1, 4'd9);
        end
        step(0, 9, 0, 0);
        check("call_timeout", 1, 4'hF);
        step(0, 9, 0, 0);
        check("busy_hold", 1, 4'hF);
        step(0, 9, 1, 0);
        check("busy_hangup", 0, 4'hF);
        step(0, 9, 0, 0);

        step(0, 2, 0, 1);
        check("ring_enter", 1, 4'hF);
        for (int k = 1; k < RT; k++) begin
            step(0, 2, 0, 1);
            check($sformatf("ring_wait%0d", k), 1, 4'hF);
        end
        step(0, 2, 0, 1);
        check("ring_timeout", 0, 4'hF);
        step(0, 2, 0, 0);
        check("ring_idle", 0, 4'hF);

        step(0, 2, 0, 1);
        check("ring2_enter", 1, 4'hF);
        step(0, 2, 0, 1);
        check("ring2_c1", 1, 4'hF);
        step(0, 2, 0, 0);
        check("ring2_drop", 0, 4'hF);

        step(1, 0, 0, 0);
        for (int k = 0; k < 3000; k++) begin
            logic r, s, v;
            logic [3:0] i;
            r = ($urandom_range(0, 199) == 0);
            s = ($urandom_range(0, 3) == 0) ? ~send : send;
            v = ($urandom_range(0, 5) == 0) ? ~recv : recv;
            i = ($urandom_range(0, 3) == 0) ? (($urandom_range(0, 1) == 1) ? 4'hF : 4'd0)
                                             : 4'($urandom_range(0, 15));
            step(r, i, s, v);
            check($sformatf("rand%0d", k), m_mode != "idle", m_num);
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end
endmodule
